// File: rtl/assoc_inst_cache_pkg.sv
// Shared types for the set-associative instruction cache: machine word type,
// address-split width helpers and the refill FSM state encoding.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package cache_pkg;
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FETCH = 1'b1
  } cache_state_e;

  function automatic int offset_w(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int xlen, input int line_bits, input int sets);
    return xlen - offset_w(line_bits) - index_w(sets);
  endfunction

  // A direct-mapped cache still carries a one-bit way number so ports never collapse to zero width.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction
endpackage

// File: rtl/assoc_inst_cache_plru_tree.sv
// Per-set tree pseudo-LRU state. Level l of the tree splits on way bit l, so
// the root separates even from odd ways.
module plru_tree
  import cache_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 32,
  localparam int IDX_W = index_w(SETS),
  localparam int WAY_W = way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] set_idx,
  input  logic [WAY_W-1:0] access_way,
  input  logic             access_en,
  input  logic             flush,
  output logic [WAY_W-1:0] victim
);

  if (WAYS == 1) begin : g_direct
    assign victim = '0;
  end else begin : g_tree
    localparam int LVL    = $clog2(WAYS);
    localparam int NODES  = WAYS - 1;
    localparam int NODE_W = (NODES > 1) ? $clog2(NODES) : 1;

    logic [NODES-1:0] bits_q [SETS];
    logic [NODES-1:0] bits_d [SETS];

    // Each node bit names the half the next victim comes from.
    always_comb begin
      int path;
      int node;
      path = 0;
      node = 0;
      for (int l = 0; l < LVL; l++) begin
        node = (1 << l) - 1 + path;
        if (bits_q[set_idx][NODE_W'(node)]) path = path | (1 << l);
      end
      victim = WAY_W'(path);
    end

    // NOTE: every always_comb output gets a full default first so no path can infer a latch.
    always_comb begin
      int aw;
      int node;
      bits_d = bits_q;
      aw     = int'(access_way);
      node   = 0;
      if (flush) begin
        for (int s = 0; s < SETS; s++) bits_d[s] = '0;
      end else if (access_en) begin
        for (int l = 0; l < LVL; l++) begin
          node = (1 << l) - 1 + (aw & ((1 << l) - 1));
          bits_d[set_idx][NODE_W'(node)] = (((aw >> l) & 1) == 0);
        end
      end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
      end else begin
        bits_q <= bits_d;
      end
    end
  end

endmodule

// File: rtl/assoc_inst_cache.sv
// N-way set-associative read-only instruction cache with one-entry lookup
// register, tree-PLRU replacement, whole-cache flush and hit/miss counters.
module assoc_inst_cache
  import rv32i_types::*, cache_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int LINE_BITS = 256,
  parameter int SETS      = 32,
  parameter int WAYS      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      mem_address,
  input  logic                 mem_read,
  output logic                 mem_resp,
  output logic [XLEN-1:0]      mem_rdata,
  input  logic                 flush,
  output logic [XLEN-1:0]      pmem_address,
  output logic                 pmem_read,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output rv32i_word            hit_count,
  output rv32i_word            miss_count
);

  localparam int OFF_W  = offset_w(LINE_BITS);
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(XLEN, LINE_BITS, SETS);
  localparam int BYTE_W = $clog2(XLEN / 8);
  localparam int WSEL_W = OFF_W - BYTE_W;
  localparam int WORDS  = LINE_BITS / XLEN;
  localparam int WAY_W  = way_w(WAYS);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  index;
    logic [WSEL_W-1:0] word;
    logic [BYTE_W-1:0] byte_off;
  } addr_t;

  cache_state_e state_q, state_d;
  logic         s1_valid_q, s1_valid_d;
  addr_t        s1_addr_q, s1_addr_d;
  logic         drop_pending_q, drop_pending_d;
  logic         gap_q, gap_d;
  rv32i_word    hit_count_q, hit_count_d;
  rv32i_word    miss_count_q, miss_count_d;
  logic [SETS-1:0] valid_q [WAYS];
  logic [SETS-1:0] valid_d [WAYS];

  logic [TAG_W-1:0]     tag_q  [WAYS][SETS];
  logic [LINE_BITS-1:0] data_q [WAYS][SETS];

  logic                 hit_any, hit, fill;
  logic [WAY_W-1:0]     hit_way, inv_way, plru_victim, victim_way;
  logic                 inv_found;
  logic [LINE_BITS-1:0] hit_line;
  logic                 unused_byte_off;

  // Instructions are word-aligned, so the byte offset never selects anything.
  assign unused_byte_off = ^s1_addr_q.byte_off;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid_q[w][s1_addr_q.index] &&
          tag_q[w][s1_addr_q.index] == s1_addr_q.tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit      = s1_valid_q && (state_q == ST_RUN) && !flush && hit_any;
  assign hit_line = data_q[hit_way][s1_addr_q.index];

  always_comb begin
    mem_rdata = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (hit && WSEL_W'(k) == s1_addr_q.word) mem_rdata = hit_line[k*XLEN +: XLEN];
    end
  end

  // Fill the lowest empty way before disturbing any resident line.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[w][s1_addr_q.index]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim_way = inv_found ? inv_way : plru_victim;

  plru_tree #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_idx    (s1_addr_q.index),
    .access_way (hit ? hit_way : victim_way),
    .access_en  (hit || fill),
    .flush      (flush),
    .victim     (plru_victim)
  );

  always_comb begin
    state_d        = state_q;
    s1_valid_d     = s1_valid_q;
    s1_addr_d      = s1_addr_q;
    drop_pending_d = drop_pending_q;
    gap_d          = gap_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    fill           = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (s1_valid_q && !hit && !flush) begin
          state_d = ST_FETCH;
          if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
        end
        if (!s1_valid_q || hit) begin
          s1_valid_d = mem_read;
          s1_addr_d  = addr_t'(mem_address);
        end
      end
      ST_FETCH: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          if (flush) drop_pending_d = 1'b1;
          if (pmem_resp) begin
            // A line requested before a flush may be stale; drop it and fetch again.
            if (drop_pending_q || flush) begin
              drop_pending_d = 1'b0;
              gap_d          = 1'b1;
            end else begin
              fill    = 1'b1;
              state_d = ST_RUN;
            end
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (hit && hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
  end

  always_comb begin
    valid_d = valid_q;
    for (int w = 0; w < WAYS; w++) begin
      if (flush) begin
        valid_d[w] = '0;
      end else if (fill && WAY_W'(w) == victim_way) begin
        valid_d[w][s1_addr_q.index] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      s1_valid_q     <= 1'b0;
      s1_addr_q      <= '0;
      drop_pending_q <= 1'b0;
      gap_q          <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else begin
      state_q        <= state_d;
      s1_valid_q     <= s1_valid_d;
      s1_addr_q      <= s1_addr_d;
      drop_pending_q <= drop_pending_d;
      gap_q          <= gap_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      valid_q        <= valid_d;
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether their contents count.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (fill && WAY_W'(w) == victim_way) begin
        tag_q[w][s1_addr_q.index]  <= s1_addr_q.tag;
        data_q[w][s1_addr_q.index] <= pmem_rdata;
      end
    end
  end

  assign mem_resp     = hit;
  assign pmem_read    = (state_q == ST_FETCH) && !gap_q;
  assign pmem_address = (state_q == ST_FETCH) ?
                        {s1_addr_q.tag, s1_addr_q.index, {OFF_W{1'b0}}} : '0;
  assign hit_count    = hit_count_q;
  assign miss_count   = miss_count_q;

endmodule

// File: tb/tb_assoc_inst_cache.sv
// Directed bench for assoc_inst_cache: expected fetch words go into a queue
// that a negedge monitor drains whenever the cache presents mem_resp.
module tb_assoc_inst_cache;
  localparam int XLEN      = 32;
  localparam int LINE_BITS = 256;
  localparam int SETS      = 32;
  localparam int WAYS      = 4;

  logic                 clk;
  logic                 rst_n;
  logic [XLEN-1:0]      mem_address;
  logic                 mem_read;
  logic                 mem_resp;
  logic [XLEN-1:0]      mem_rdata;
  logic                 flush;
  logic [XLEN-1:0]      pmem_address;
  logic                 pmem_read;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;
  logic [31:0]          hit_count;
  logic [31:0]          miss_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  assoc_inst_cache #(
    .XLEN(XLEN), .LINE_BITS(LINE_BITS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .flush        (flush),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [LINE_BITS-1:0] line_of(input logic [31:0] a);
    logic [LINE_BITS-1:0] l;
    logic [31:0]          base;
    base = {a[31:5], 5'b0};
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = mem_word(base + 32'(k * 4));
    return l;
  endfunction

  function automatic logic [LINE_BITS-1:0] bogus_line();
    logic [LINE_BITS-1:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hBAD0_0000 + 32'(k);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=%h required=no response", mem_rdata);
        end else begin
          check("rdata", mem_rdata, exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_read = 1'b0; mem_address = '0; flush = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Presents one request for a single cycle; the cache is idle so it is accepted at the next edge.
  task automatic req_start(input logic [31:0] a, input bit expect_resp);
    if (expect_resp) exp_q.push_back(mem_word(a));
    mem_address = a;
    mem_read    = 1'b1;
    @(posedge clk); #1;
    mem_read    = 1'b0;
  endtask

  task automatic wait_pmem(input logic [31:0] a);
    int n = 0;
    while (pmem_read !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("pmem_read_seen", 32'(pmem_read), 32'd1);
    check("pmem_address", pmem_address, a);
  endtask

  task automatic return_line(input logic [LINE_BITS-1:0] line, input int lat);
    repeat (lat) begin @(posedge clk); #1; end
    check("pmem_read_held", 32'(pmem_read), 32'd1);
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
  endtask

  // The response must appear in the first cycle the lookup can hit.
  task automatic wait_resp(input string name);
    @(negedge clk);
    check(name, 32'(mem_resp), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic miss_fill(input logic [31:0] a);
    req_start(a, 1'b1);
    wait_pmem(a);
    return_line(line_of(a), 2);
    wait_resp("miss_replay_resp");
  endtask

  initial begin
    rst_n = 1'b0;
    fork
      monitor();
    join_none
    do_reset();

    check("rst_mem_resp", 32'(mem_resp), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_pmem_read", 32'(pmem_read), 32'd0);
    check("rst_pmem_address", pmem_address, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);

    // Cold miss, replay hit, then a hit on word 1 of the same line.
    miss_fill(32'h0000_0040);
    check("cold_miss_count", miss_count, 32'd1);
    check("cold_hit_count", hit_count, 32'd1);
    req_start(32'h0000_0044, 1'b1);
    wait_resp("hit_latency");
    check("word1_hit_count", hit_count, 32'd2);
    check("word1_miss_count", miss_count, 32'd1);

    // Eight back-to-back word reads inside the resident line.
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        exp_q.push_back(mem_word(32'h40 + 32'(k * 4)));
        mem_address = 32'h40 + 32'(k * 4);
        mem_read    = 1'b1;
      end else begin
        mem_read    = 1'b0;
      end
      if (k > 0) begin
        @(negedge clk);
        check("stream_resp", 32'(mem_resp), 32'd1);
        check("stream_no_pmem", 32'(pmem_read), 32'd0);
      end
      @(posedge clk); #1;
    end
    check("stream_hit_count", hit_count, 32'd10);

    // PLRU eviction in set 2.
    do_reset();
    miss_fill(32'h0000_0040);
    miss_fill(32'h0000_0440);
    miss_fill(32'h0000_0840);
    miss_fill(32'h0000_0C40);
    req_start(32'h0000_0040, 1'b1);
    wait_resp("touch_hit");
    miss_fill(32'h0000_1040);
    req_start(32'h0000_0040, 1'b1);
    wait_resp("survivor_hit");
    miss_fill(32'h0000_0440);
    check("plru_hit_count", hit_count, 32'd8);
    check("plru_miss_count", miss_count, 32'd6);

    // Flush while the line fetch is outstanding.
    do_reset();
    req_start(32'h0000_0100, 1'b1);
    wait_pmem(32'h0000_0100);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    return_line(bogus_line(), 1);
    @(negedge clk);
    check("pmem_read_gap", 32'(pmem_read), 32'd0);
    check("gap_no_resp", 32'(mem_resp), 32'd0);
    @(posedge clk); #1;
    check("pmem_reissue", 32'(pmem_read), 32'd1);
    wait_pmem(32'h0000_0100);
    return_line(line_of(32'h0000_0100), 2);
    wait_resp("refetch_resp");
    check("flush_fetch_miss_count", miss_count, 32'd1);
    check("flush_fetch_hit_count", hit_count, 32'd1);

    // Flush in RUN coinciding with a would-be hit.
    do_reset();
    miss_fill(32'h0000_0200);
    exp_q.push_back(mem_word(32'h0000_0200));
    mem_address = 32'h0000_0200;
    mem_read    = 1'b1;
    @(posedge clk); #1;
    mem_read    = 1'b0;
    flush       = 1'b1;
    @(negedge clk);
    check("flush_forces_no_resp", 32'(mem_resp), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("hit_count_after_flush", hit_count, 32'd1);
    wait_pmem(32'h0000_0200);
    return_line(line_of(32'h0000_0200), 3);
    wait_resp("post_flush_resp");
    check("flush_run_miss_count", miss_count, 32'd2);

    // Asynchronous reset in the middle of a miss.
    do_reset();
    req_start(32'h0000_0000, 1'b0);
    wait_pmem(32'h0000_0000);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("pmem_read_async_drop", 32'(pmem_read), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pmem_rdata = bogus_line();
    pmem_resp  = 1'b1;
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    @(negedge clk);
    check("late_resp_ignored", 32'(pmem_read), 32'd0);
    check("late_resp_no_hit", 32'(mem_resp), 32'd0);
    @(posedge clk); #1;
    miss_fill(32'h0000_0000);
    check("post_reset_miss_count", miss_count, 32'd1);

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
